// File: rtl/b_id_ex_reg.sv
// ID/EX register: 1-cycle capture, holds on ext_stall, bubbles on flush or load-use, hazard_stall holds IF and IF/ID.
// Optional macro B_ID_EX_WB_BYPASS_EN adds a write-back forward onto the rs/rt read data.
module b_id_ex_reg #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            i_b_id_ex_clk,
  input  logic            i_b_id_ex_rst,
  input  logic            i_b_id_ex_valid,
  input  logic [DW-1:0]   i_b_id_ex_rs_data,
  input  logic [DW-1:0]   i_b_id_ex_rt_data,
  input  logic [DW-1:0]   i_b_id_ex_imm,
  input  logic [AW-1:0]   i_b_id_ex_rs_addr,
  input  logic [AW-1:0]   i_b_id_ex_rt_addr,
  input  logic [AW-1:0]   i_b_id_ex_rd_addr,
  input  logic [4:0]      i_b_id_ex_shamt,
  input  logic [3:0]      i_b_id_ex_alu_ctrl,
  input  logic            i_b_id_ex_alu_src,
  input  logic            i_b_id_ex_reg_dst,
  input  logic            i_b_id_ex_reg_write,
  input  logic            i_b_id_ex_mem_read,
  input  logic            i_b_id_ex_mem_write,
  input  logic            i_b_id_ex_mem_to_reg,
  input  logic            i_b_id_ex_ext_stall,
  input  logic            i_b_id_ex_flush,
`ifdef B_ID_EX_WB_BYPASS_EN
  input  logic            i_b_id_ex_wb_reg_write,
  input  logic [AW-1:0]   i_b_id_ex_wb_addr,
  input  logic [DW-1:0]   i_b_id_ex_wb_data,
`endif
  output logic [DW-1:0]   o_b_id_ex_operand_1,
  output logic [DW-1:0]   o_b_id_ex_operand_2,
  output logic [4:0]      o_b_id_ex_shamt,
  output logic [3:0]      o_b_id_ex_alu_ctrl,
  output logic [DW-1:0]   o_b_id_ex_store_data,
  output logic [AW-1:0]   o_b_id_ex_dest_addr,
  output logic            o_b_id_ex_reg_write,
  output logic            o_b_id_ex_mem_read,
  output logic            o_b_id_ex_mem_write,
  output logic            o_b_id_ex_mem_to_reg,
  output logic            o_b_id_ex_valid,
  output logic            o_b_id_ex_hazard_stall,
  output logic [CNTW-1:0] o_b_id_ex_bubble_cnt
);

  typedef struct packed {
    logic [DW-1:0] operand_1;
    logic [DW-1:0] operand_2;
    logic [DW-1:0] store_data;
    logic [AW-1:0] dest_addr;
    logic [4:0]    shamt;
    logic [3:0]    alu_ctrl;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          valid;
  } ex_t;

  ex_t             ex_q;
  ex_t             cap_d;
  logic [CNTW-1:0] cnt_q;
  logic [DW-1:0]   rs_val;
  logic [DW-1:0]   rt_val;
  logic            hazard;

`ifdef B_ID_EX_WB_BYPASS_EN
  // Register file writes in the same cycle it is read; forward the write-back value.
  always_comb begin
    rs_val = i_b_id_ex_rs_data;
    rt_val = i_b_id_ex_rt_data;
    if (i_b_id_ex_wb_reg_write && (i_b_id_ex_wb_addr != '0) && (i_b_id_ex_wb_addr == i_b_id_ex_rs_addr))
      rs_val = i_b_id_ex_wb_data;
    if (i_b_id_ex_wb_reg_write && (i_b_id_ex_wb_addr != '0) && (i_b_id_ex_wb_addr == i_b_id_ex_rt_addr))
      rt_val = i_b_id_ex_wb_data;
  end
`else
  assign rs_val = i_b_id_ex_rs_data;
  assign rt_val = i_b_id_ex_rt_data;
`endif

  // rt is compared even for I-type users: conservative, costs at most a spurious bubble.
  assign hazard = !i_b_id_ex_flush && i_b_id_ex_valid && ex_q.valid && ex_q.mem_read &&
                  (ex_q.dest_addr != '0) &&
                  ((ex_q.dest_addr == i_b_id_ex_rs_addr) || (ex_q.dest_addr == i_b_id_ex_rt_addr));

  always_comb begin
    cap_d = '0;
    if (i_b_id_ex_valid) begin
      cap_d.operand_1  = rs_val;
      cap_d.operand_2  = i_b_id_ex_alu_src ? i_b_id_ex_imm : rt_val;
      cap_d.store_data = rt_val;
      cap_d.dest_addr  = i_b_id_ex_reg_dst ? i_b_id_ex_rd_addr : i_b_id_ex_rt_addr;
      cap_d.shamt      = i_b_id_ex_shamt;
      cap_d.alu_ctrl   = i_b_id_ex_alu_ctrl;
      cap_d.reg_write  = i_b_id_ex_reg_write;
      cap_d.mem_read   = i_b_id_ex_mem_read;
      cap_d.mem_write  = i_b_id_ex_mem_write;
      cap_d.mem_to_reg = i_b_id_ex_mem_to_reg;
      cap_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge i_b_id_ex_clk) begin
    if (i_b_id_ex_rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (i_b_id_ex_flush) begin
      ex_q <= '0;
    end else if (i_b_id_ex_ext_stall) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= '0;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNTW'(1);
    end else begin
      ex_q <= cap_d;
    end
  end

  assign o_b_id_ex_operand_1    = ex_q.operand_1;
  assign o_b_id_ex_operand_2    = ex_q.operand_2;
  assign o_b_id_ex_store_data   = ex_q.store_data;
  assign o_b_id_ex_dest_addr    = ex_q.dest_addr;
  assign o_b_id_ex_shamt        = ex_q.shamt;
  assign o_b_id_ex_alu_ctrl     = ex_q.alu_ctrl;
  assign o_b_id_ex_reg_write    = ex_q.reg_write;
  assign o_b_id_ex_mem_read     = ex_q.mem_read;
  assign o_b_id_ex_mem_write    = ex_q.mem_write;
  assign o_b_id_ex_mem_to_reg   = ex_q.mem_to_reg;
  assign o_b_id_ex_valid        = ex_q.valid;
  assign o_b_id_ex_hazard_stall = hazard;
  assign o_b_id_ex_bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_b_id_ex_reg.sv
// Directed bench for b_id_ex_reg; counter narrowed to 8 bits so saturation is reachable quickly.
module tb_b_id_ex_reg;
  localparam int CW = 8;

  typedef struct packed {
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [31:0]   sd;
    logic [4:0]    dest;
    logic [4:0]    shamt;
    logic [3:0]    ctrl;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          mtr;
    logic          vld;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, valid, alu_src, reg_dst, rw, mr, mw, mtr, ext_stall, flush;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [3:0]  alu_ctrl;
`ifdef B_ID_EX_WB_BYPASS_EN
  logic        wb_rw;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`endif
  logic [31:0] o_op1, o_op2, o_sd;
  logic [4:0]  o_dest, o_shamt;
  logic [3:0]  o_ctrl;
  logic        o_rw, o_mr, o_mw, o_mtr, o_vld, o_hz;
  logic [CW-1:0] o_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t lw8_e, sw_e, add_e, sat_e;

  always #5 clk = ~clk;

  b_id_ex_reg #(.DW(32), .AW(5), .CNTW(CW)) dut (
    .i_b_id_ex_clk(clk), .i_b_id_ex_rst(rst), .i_b_id_ex_valid(valid),
    .i_b_id_ex_rs_data(rs_data), .i_b_id_ex_rt_data(rt_data), .i_b_id_ex_imm(imm),
    .i_b_id_ex_rs_addr(rs_addr), .i_b_id_ex_rt_addr(rt_addr), .i_b_id_ex_rd_addr(rd_addr),
    .i_b_id_ex_shamt(shamt), .i_b_id_ex_alu_ctrl(alu_ctrl), .i_b_id_ex_alu_src(alu_src),
    .i_b_id_ex_reg_dst(reg_dst), .i_b_id_ex_reg_write(rw), .i_b_id_ex_mem_read(mr),
    .i_b_id_ex_mem_write(mw), .i_b_id_ex_mem_to_reg(mtr), .i_b_id_ex_ext_stall(ext_stall),
    .i_b_id_ex_flush(flush),
`ifdef B_ID_EX_WB_BYPASS_EN
    .i_b_id_ex_wb_reg_write(wb_rw), .i_b_id_ex_wb_addr(wb_addr), .i_b_id_ex_wb_data(wb_data),
`endif
    .o_b_id_ex_operand_1(o_op1), .o_b_id_ex_operand_2(o_op2), .o_b_id_ex_shamt(o_shamt),
    .o_b_id_ex_alu_ctrl(o_ctrl), .o_b_id_ex_store_data(o_sd), .o_b_id_ex_dest_addr(o_dest),
    .o_b_id_ex_reg_write(o_rw), .o_b_id_ex_mem_read(o_mr), .o_b_id_ex_mem_write(o_mw),
    .o_b_id_ex_mem_to_reg(o_mtr), .o_b_id_ex_valid(o_vld), .o_b_id_ex_hazard_stall(o_hz),
    .o_b_id_ex_bubble_cnt(o_cnt)
  );

  function automatic exp_t e_ins(logic [31:0] op1, logic [31:0] op2, logic [31:0] sd,
                                 logic [4:0] dest, logic [4:0] sh, logic [3:0] ctrl,
                                 logic w, logic r, logic m, logic t, logic [CW-1:0] c);
    exp_t e;
    e = '{op1: op1, op2: op2, sd: sd, dest: dest, shamt: sh, ctrl: ctrl,
          rw: w, mr: r, mw: m, mtr: t, vld: 1'b1, cnt: c};
    return e;
  endfunction

  function automatic exp_t bubble(logic [CW-1:0] c);
    exp_t e;
    e = '0;
    e.cnt = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] im, input logic [4:0] rsa, input logic [4:0] rta,
                        input logic [4:0] rda, input logic [4:0] sh, input logic [3:0] ctrl,
                        input logic src, input logic dst, input logic w, input logic r,
                        input logic m, input logic t);
    valid = v; rs_data = rsd; rt_data = rtd; imm = im;
    rs_addr = rsa; rt_addr = rta; rd_addr = rda; shamt = sh; alu_ctrl = ctrl;
    alu_src = src; reg_dst = dst; rw = w; mr = r; mw = m; mtr = t;
  endtask

  // Expected value is queued with the stimulus and retired one edge later.
  task automatic step(input string tag, input exp_t e);
    exp_t want, got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    got  = {o_op1, o_op2, o_sd, o_dest, o_shamt, o_ctrl, o_rw, o_mr, o_mw, o_mtr, o_vld, o_cnt};
    chk(tag, 128'(got), 128'(want));
  endtask

  task automatic hz(input string tag, input logic e);
    #1;
    chk(tag, 128'(o_hz), 128'(e));
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; flush = 1'b0;
`ifdef B_ID_EX_WB_BYPASS_EN
    wb_rw = 1'b0; wb_addr = '0; wb_data = '0;
`endif
    set_id(1'b1, $urandom, $urandom, $urandom, 5'd8, 5'd8, 5'd3, 5'd1, 4'h2, 1, 0, 1, 1, 0, 1);
    #1;
    step("reset0", '0);
    set_id(1'b1, $urandom, $urandom, $urandom, 5'd4, 5'd9, 5'd3, 5'd7, 4'h6, 0, 1, 1, 1, 1, 1);
    step("reset1", '0);
    hz("reset_hz", 1'b0);
    rst = 1'b0;

    set_id(1, 32'h1, 32'h55, 32'h2, 5'd1, 5'd5, 5'd9, 5'd0, 4'h0, 1, 0, 1, 0, 0, 0);
    hz("addi_hz", 1'b0);
    step("addi", e_ins(32'h1, 32'h2, 32'h55, 5'd5, 5'd0, 4'h0, 1, 0, 0, 0, 0));

    set_id(1, 32'h10, 32'h20, 32'hFFFF_FFF0, 5'd2, 5'd6, 5'd7, 5'd3, 4'h2, 0, 1, 1, 0, 0, 0);
    step("add_r", e_ins(32'h10, 32'h20, 32'h20, 5'd7, 5'd3, 4'h2, 1, 0, 0, 0, 0));

    // load-use on rs, with one ext_stall cycle first
    lw8_e = e_ins(32'h100, 32'h4, 32'h7, 5'd8, 5'd0, 4'h0, 1, 1, 0, 1, 0);
    set_id(1, 32'h100, 32'h7, 32'h4, 5'd1, 5'd8, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    hz("lw8_hz", 1'b0);
    step("lw8", lw8_e);
    set_id(1, 32'hA, 32'hB, 32'h0, 5'd8, 5'd3, 5'd10, 5'd0, 4'h2, 0, 1, 1, 0, 0, 0);
    ext_stall = 1'b1;
    hz("lu_hz_stalled", 1'b1);
    step("lu_hold", lw8_e);
    ext_stall = 1'b0;
    hz("lu_hz", 1'b1);
    step("lu_bubble", bubble(1));
    hz("lu_hz_drop", 1'b0);
    add_e = e_ins(32'hA, 32'hB, 32'hB, 5'd10, 5'd0, 4'h2, 1, 0, 0, 0, 1);
    step("lu_capture", add_e);

    // load-use through rt only
    set_id(1, 32'h200, 32'h1, 32'h8, 5'd2, 5'd9, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    step("lw9", e_ins(32'h200, 32'h8, 32'h1, 5'd9, 5'd0, 4'h0, 1, 1, 0, 1, 1));
    set_id(1, 32'h300, 32'h1234, 32'hC, 5'd2, 5'd9, 5'd0, 5'd0, 4'h0, 1, 0, 0, 0, 1, 0);
    hz("sw_hz", 1'b1);
    step("sw_bubble", bubble(2));
    sw_e = e_ins(32'h300, 32'hC, 32'h1234, 5'd9, 5'd0, 4'h0, 0, 0, 1, 0, 2);
    step("sw", sw_e);

    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, $urandom, $urandom, $urandom, 5'(i + 11), 5'(i + 14), 5'(i + 17), 5'(i), 4'(i),
             1, 1, 1, 1, 1, 1);
      step("freeze", sw_e);
    end
    ext_stall = 1'b0;
    set_id(1, 32'h5, 32'h6, 32'h7, 5'd4, 5'd4, 5'd4, 5'd0, 4'h1, 0, 0, 1, 0, 0, 0);
    step("thaw", e_ins(32'h5, 32'h6, 32'h6, 5'd4, 5'd0, 4'h1, 1, 0, 0, 0, 2));

    // flush beats ext_stall and masks the hazard
    lw8_e.cnt = 2;
    set_id(1, 32'h100, 32'h7, 32'h4, 5'd1, 5'd8, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    step("lw8b", lw8_e);
    set_id(1, 32'hA, 32'hB, 32'h0, 5'd8, 5'd3, 5'd10, 5'd0, 4'h2, 0, 1, 1, 0, 0, 0);
    flush = 1'b1; ext_stall = 1'b1;
    hz("flush_hz", 1'b0);
    step("flush", bubble(2));
    flush = 1'b0; ext_stall = 1'b0;
    add_e.cnt = 2;
    step("post_flush", add_e);

    // $0 as load destination never stalls
    set_id(1, 32'h40, 32'h0, 32'h10, 5'd1, 5'd0, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    step("lw0", e_ins(32'h40, 32'h10, 32'h0, 5'd0, 5'd0, 4'h0, 1, 1, 0, 1, 2));
    set_id(1, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd12, 5'd0, 4'h2, 0, 1, 1, 0, 0, 0);
    hz("r0_hz", 1'b0);
    step("use_r0", e_ins(32'h1, 32'h2, 32'h2, 5'd12, 5'd0, 4'h2, 1, 0, 0, 0, 2));

    // invalid ID slot: no hazard, captured as a bubble, not counted
    set_id(1, 32'h100, 32'h7, 32'h4, 5'd1, 5'd8, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    step("lw8c", lw8_e);
    set_id(0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd8, 5'd8, 5'd8, 5'd7, 4'h5, 1, 1, 1, 1, 1, 1);
    hz("invalid_hz", 1'b0);
    step("invalid", bubble(2));

    // reset during a pending load-use
    set_id(1, 32'h100, 32'h7, 32'h4, 5'd1, 5'd8, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    step("lw8d", lw8_e);
    set_id(1, 32'hA, 32'hB, 32'h0, 5'd8, 5'd3, 5'd10, 5'd0, 4'h2, 0, 1, 1, 0, 0, 0);
    hz("rst_mid_hz", 1'b1);
    rst = 1'b1;
    step("rst_mid", '0);
    hz("rst_mid_hz_drop", 1'b0);
    rst = 1'b0;

    // self-dependent LW repeated past counter saturation
    set_id(1, 32'h100, 32'h7, 32'h4, 5'd8, 5'd8, 5'd0, 5'd0, 4'h0, 1, 0, 1, 1, 0, 1);
    sat_e = e_ins(32'h100, 32'h4, 32'h7, 5'd8, 5'd0, 4'h0, 1, 1, 0, 1, 0);
    step("sat_first", sat_e);
    for (int k = 1; k <= (1 << CW) + 3; k++) begin
      sat_e.cnt = (k > (1 << CW) - 1) ? '1 : CW'(k);
      step("sat_bubble", bubble(sat_e.cnt));
      step("sat_capture", sat_e);
    end
    chk("sat_final", 128'(o_cnt), 128'(8'hFF));

`ifdef B_ID_EX_WB_BYPASS_EN
    wb_rw = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    set_id(1, 32'h0, 32'h11, 32'h0, 5'd3, 5'd4, 5'd5, 5'd0, 4'h2, 0, 1, 1, 0, 0, 0);
    step("byp_rs", e_ins(32'hDEAD_BEEF, 32'h11, 32'h11, 5'd5, 5'd0, 4'h2, 1, 0, 0, 0, 8'hFF));
    wb_addr = 5'd0;
    step("byp_r0", e_ins(32'h0, 32'h11, 32'h11, 5'd5, 5'd0, 4'h2, 1, 0, 0, 0, 8'hFF));
    wb_addr = 5'd4;
    step("byp_rt", e_ins(32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd5, 5'd0, 4'h2, 1, 0, 0, 0, 8'hFF));
    wb_rw = 1'b0;
    step("byp_off", e_ins(32'h0, 32'h11, 32'h11, 5'd5, 5'd0, 4'h2, 1, 0, 0, 0, 8'hFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
